// File: rtl/ifetch_line_buffer_if.sv
// rtl/ifetch_line_buffer_if.sv - fetch-side and instruction-memory-side signals of the line buffer
interface ifetch_line_buffer_if;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        flush;
  logic [15:0] instr;
  logic        instr_valid;
  logic        fetch_stall;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data;

  modport master (
    output req_valid, req_addr, flush, mem_data_valid, mem_data,
    input  instr, instr_valid, fetch_stall, mem_rd_en, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, flush, mem_data_valid, mem_data,
    output instr, instr_valid, fetch_stall, mem_rd_en, mem_addr
  );
endinterface

// File: rtl/ifetch_line_buffer.sv
// rtl/ifetch_line_buffer.sv - single-line instruction fetch buffer with pipelined refill
module ifetch_line_buffer #(
  parameter int          LINE_WORDS = 4,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input logic              clk,
  input logic              rst,
  ifetch_line_buffer_if.slave bus
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [2:0] WORDS = 3'(LINE_WORDS);
  localparam logic [2:0] LAST  = 3'(LINE_WORDS - 1);

  state_t      state;
  logic        line_valid;
  logic [12:0] line_tag;
  logic [15:0] line_data [LINE_WORDS];
  logic [2:0]  issue_cnt;
  logic [2:0]  recv_cnt;
  logic        rd_en_q;
  logic [15:0] addr_q;

  logic        hit;
  logic        miss;
  logic [1:0]  word_sel;
  logic        addr_lsb_unused;

  // Odd addresses fetch the containing word.
  assign addr_lsb_unused = bus.req_addr[0];
  assign word_sel        = bus.req_addr[2:1];

  assign hit  = (state == IDLE) && bus.req_valid && line_valid &&
                (line_tag == bus.req_addr[15:3]);
  assign miss = (state == IDLE) && bus.req_valid && !hit;

  assign bus.instr_valid = hit && !bus.flush;
  assign bus.instr       = bus.instr_valid ? line_data[word_sel] : NOP_INSTR;
  assign bus.fetch_stall = (state == FILL) || miss;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_addr    = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      line_valid <= 1'b0;
      line_tag   <= '0;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          rd_en_q <= 1'b0;
          // The first read goes out on the miss edge so reads occupy the four cycles after the miss.
          if (miss) begin
            line_valid <= 1'b0;
            line_tag   <= bus.req_addr[15:3];
            rd_en_q    <= 1'b1;
            addr_q     <= {bus.req_addr[15:3], 3'b000};
            issue_cnt  <= 3'd1;
            recv_cnt   <= '0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (issue_cnt < WORDS) begin
            rd_en_q   <= 1'b1;
            addr_q    <= {line_tag, 3'b000} + {12'd0, issue_cnt, 1'b0};
            issue_cnt <= issue_cnt + 3'd1;
          end else begin
            rd_en_q <= 1'b0;
          end
          if (bus.mem_data_valid) begin
            line_data[recv_cnt[1:0]] <= bus.mem_data;
            recv_cnt                 <= recv_cnt + 3'd1;
            if (recv_cnt == LAST) begin
              line_valid <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// tb/tb_ifetch_line_buffer.sv - scoreboard bench for the instruction fetch line buffer
module tb_ifetch_line_buffer;

  logic clk = 1'b0;
  logic rst;

  ifetch_line_buffer_if bus ();

  ifetch_line_buffer #(
    .LINE_WORDS (4),
    .NOP_INSTR  (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 1;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_instr_q[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] idx;
    idx = {14'd0, a[2:1]} + 16'd1;
    if (a < 16'd8) return idx * 16'h1111;
    return 16'hC000 | a;
  endfunction

  // Fixed-latency memory: a request seen in cycle c is answered in cycle c+lat.
  logic        pipe_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] pipe_a [3] = '{16'd0, 16'd0, 16'd0};

  always @(posedge clk) begin
    pipe_v[0] <= bus.mem_rd_en;
    pipe_a[0] <= bus.mem_addr;
    pipe_v[1] <= pipe_v[0];
    pipe_a[1] <= pipe_a[0];
    pipe_v[2] <= pipe_v[1];
    pipe_a[2] <= pipe_a[1];
  end

  assign bus.mem_data_valid = pipe_v[lat-1];
  assign bus.mem_data       = mem_word(pipe_a[lat-1]);

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (bus.mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b expected 0", bus.mem_rd_en); end
    n_cmp++; if (bus.mem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h expected 0000", bus.mem_addr); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_instr_valid: got %b expected 0", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 16'h0000) begin n_bad++; $display("FAIL reset_instr: got %h expected 0000", bus.instr); end
    n_cmp++; if (bus.fetch_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", bus.fetch_stall); end
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    lat = 1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0100;
    repeat (3) next();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL midreset_async_rd_en: got %b expected 0", bus.mem_rd_en); end
    n_cmp++; if (bus.fetch_stall !== 1'b0) begin n_bad++; $display("FAIL midreset_async_stall: got %b expected 0", bus.fetch_stall); end
    #1;
    rst = 1'b0;
    next();
    #1;
    n_cmp++; if (bus.mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL midreset_rd_en: got %b expected 0", bus.mem_rd_en); end
    n_cmp++; if (bus.fetch_stall !== 1'b0) begin n_bad++; $display("FAIL midreset_stall: got %b expected 0", bus.fetch_stall); end
    repeat (2) next();
    // Late responses must not have validated the line: the same address still misses.
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0100;
    #1;
    n_cmp++; if (bus.fetch_stall !== 1'b1) begin n_bad++; $display("FAIL midreset_line_invalid_stall: got %b expected 1", bus.fetch_stall); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_line_invalid_valid: got %b expected 0", bus.instr_valid); end
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    rst = 1'b0;
    repeat (4) next();
  endtask

  task automatic test_miss_fill(input logic [15:0] addr, input int l);
    logic [15:0] base;
    logic [15:0] got_exp;
    logic        exp_bit;
    lat = l;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.flush     = 1'b0;
    base = {addr[15:3], 3'b000};
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 16'(2*i));
    exp_instr_q.push_back(mem_word({addr[15:1], 1'b0}));
    for (int k = 0; k <= 5 + l; k++) begin
      #1;
      exp_bit = (k <= 4 + l);
      n_cmp++; if (bus.fetch_stall !== exp_bit) begin n_bad++; $display("FAIL fill_stall addr=%h k=%0d: got %b expected %b", addr, k, bus.fetch_stall, exp_bit); end
      exp_bit = (k >= 1 && k <= 4);
      n_cmp++; if (bus.mem_rd_en !== exp_bit) begin n_bad++; $display("FAIL fill_rd_en addr=%h k=%0d: got %b expected %b", addr, k, bus.mem_rd_en, exp_bit); end
      if (bus.mem_rd_en === 1'b1) begin
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_bad++; $display("FAIL fill_addr_extra k=%0d: got %h expected no read", k, bus.mem_addr);
        end else begin
          got_exp = exp_addr_q.pop_front();
          if (bus.mem_addr !== got_exp) begin n_bad++; $display("FAIL fill_addr k=%0d: got %h expected %h", k, bus.mem_addr, got_exp); end
        end
      end
      if (k < 5 + l) begin
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL fill_instr_valid_low k=%0d: got %b expected 0", k, bus.instr_valid); end
        next();
      end else begin
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_bad++; $display("FAIL fill_instr_valid addr=%h: got %b expected 1", addr, bus.instr_valid); end
        got_exp = exp_instr_q.pop_front();
        n_cmp++; if (bus.instr !== got_exp) begin n_bad++; $display("FAIL fill_instr addr=%h: got %h expected %h", addr, bus.instr, got_exp); end
      end
    end
    next();
  endtask

  task automatic test_hits();
    logic [15:0] addrs [4] = '{16'h0002, 16'h0004, 16'h0006, 16'h0005};
    logic [15:0] words [4] = '{16'h2222, 16'h3333, 16'h4444, 16'h3333};
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = addrs[i];
      exp_instr_q.push_back(words[i]);
      #1;
      n_cmp++; if (bus.fetch_stall !== 1'b0) begin n_bad++; $display("FAIL hit_stall addr=%h: got %b expected 0", addrs[i], bus.fetch_stall); end
      n_cmp++; if (bus.instr_valid !== 1'b1) begin n_bad++; $display("FAIL hit_valid addr=%h: got %b expected 1", addrs[i], bus.instr_valid); end
      e = exp_instr_q.pop_front();
      n_cmp++; if (bus.instr !== e) begin n_bad++; $display("FAIL hit_instr addr=%h: got %h expected %h", addrs[i], bus.instr, e); end
      next();
    end
    bus.req_addr = 16'h0002;
    bus.flush    = 1'b1;
    #1;
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL hit_flush_valid: got %b expected 0", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 16'h0000) begin n_bad++; $display("FAIL hit_flush_instr: got %h expected 0000", bus.instr); end
    n_cmp++; if (bus.fetch_stall !== 1'b0) begin n_bad++; $display("FAIL hit_flush_stall: got %b expected 0", bus.fetch_stall); end
    next();
    bus.flush = 1'b0;
  endtask

  task automatic test_replace();
    test_miss_fill(16'h0008, 1);
    test_miss_fill(16'h0000, 1);
  endtask

  task automatic test_flush_redirect();
    logic        exp_bit;
    logic [15:0] e;
    test_miss_fill(16'h0008, 1);
    lat = 1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0000;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(16'(2*i));
    for (int k = 0; k <= 12; k++) begin
      if (k == 2) begin
        bus.flush    = 1'b1;
        bus.req_addr = 16'h0040;
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(16'h0040 + 16'(2*i));
        exp_instr_q.push_back(mem_word(16'h0040));
      end
      if (k == 3) bus.flush = 1'b0;
      #1;
      exp_bit = (k <= 11);
      n_cmp++; if (bus.fetch_stall !== exp_bit) begin n_bad++; $display("FAIL redirect_stall k=%0d: got %b expected %b", k, bus.fetch_stall, exp_bit); end
      exp_bit = (k >= 1 && k <= 4) || (k >= 7 && k <= 10);
      n_cmp++; if (bus.mem_rd_en !== exp_bit) begin n_bad++; $display("FAIL redirect_rd_en k=%0d: got %b expected %b", k, bus.mem_rd_en, exp_bit); end
      if (bus.mem_rd_en === 1'b1) begin
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_bad++; $display("FAIL redirect_addr_extra k=%0d: got %h expected no read", k, bus.mem_addr);
        end else begin
          e = exp_addr_q.pop_front();
          if (bus.mem_addr !== e) begin n_bad++; $display("FAIL redirect_addr k=%0d: got %h expected %h", k, bus.mem_addr, e); end
        end
      end
      exp_bit = (k == 12);
      n_cmp++; if (bus.instr_valid !== exp_bit) begin n_bad++; $display("FAIL redirect_valid k=%0d: got %b expected %b", k, bus.instr_valid, exp_bit); end
      if (k == 12) begin
        e = exp_instr_q.pop_front();
        n_cmp++; if (bus.instr !== e) begin n_bad++; $display("FAIL redirect_instr: got %h expected %h", bus.instr, e); end
      end
      next();
    end
  endtask

  task automatic test_latency3();
    test_miss_fill(16'h0010, 3);
    bus.req_valid = 1'b0;
    lat = 1;
    repeat (4) next();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.flush     = 1'b0;
    test_reset();
    test_reset_mid_fill();
    test_miss_fill(16'h0000, 1);
    test_hits();
    test_replace();
    test_flush_redirect();
    test_latency3();
    n_cmp++; if (exp_addr_q.size() != 0) begin n_bad++; $display("FAIL addr_queue_drained: got %0d left expected 0", exp_addr_q.size()); end
    n_cmp++; if (exp_instr_q.size() != 0) begin n_bad++; $display("FAIL instr_queue_drained: got %0d left expected 0", exp_instr_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
